// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and divide sequencer in front of a multi-cycle divider core.
// Launch costs one cycle plus core latency; stall holds IF..EX until core_ready or a flush.
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic        div_sign,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        stall,
  output logic        core_start,
  output logic        core_sign,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_ready,
  input  logic [63:0] core_result
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, lo_q;
  logic        div_zero;
  logic        div_done;
  logic        b_nonzero;

  assign b_nonzero = (div_b != 32'd0);

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    stall      = 1'b0;
    div_zero   = 1'b0;
    div_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // core_ready here belongs to an abandoned divide and is ignored
        if (div_req && !flush) begin
          if (b_nonzero) begin
            core_start = 1'b1;
            stall      = 1'b1;
            state_d    = WAIT;
          end else begin
            div_zero   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (core_ready) begin
          div_done = 1'b1;
          state_d  = IDLE;
        end else begin
          stall    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      core_start = 1'b0;
      stall      = 1'b0;
    end
  end

  assign core_sign = div_sign;
  assign core_a    = div_a;
  assign core_b    = div_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (!flush) begin
        if (div_done) begin
          hi_q <= core_result[63:32];
          lo_q <= core_result[31:0];
        end else if (div_zero) begin
          // divide-by-zero result is defined here so the core never sees b==0
          hi_q <= div_a;
          lo_q <= 32'hFFFF_FFFF;
        end else begin
          if (mthi) hi_q <= mt_data;
          if (mtlo) lo_q <= mt_data;
        end
      end
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- div_req  in  1  EX stage holds a DIV/DIVU; held high while stall is high.
- div_sign  in  1  1 = DIV (signed), 0 = DIVU.
- div_a  in  32  dividend.
- div_b  in  32  divisor.
- flush  in  1  pipeline flush (exception or eret); kills the in-flight divide.
- mthi, mtlo  in  1 each  write-enables for HI and LO.
- mt_data  in  32  write data for HI/LO.
- hi_out, lo_out  out  32 each  architectural HI and LO registers.
- stall  out  1  combinational request to freeze IF..EX.
- core_start  out  1  one-cycle launch pulse to the divider core.
- core_sign  out  1  signedness sent to the core.
- core_a, core_b  out  32 each  operands sent to the core.
- core_ready  in  1  one-cycle result-valid pulse from the core.
- core_result  in  64  [63:32] = remainder, [31:0] = quotient.

Function
REQ-002 The block SHALL implement FSM states IDLE and WAIT, encoded in registers.
REQ-003 In IDLE, with div_req=1, flush=0 and div_b!=0, the block SHALL:
- pulse core_start for exactly one cycle;
- drive core_a=div_a, core_b=div_b, core_sign=div_sign combinationally that same cycle;
- move to WAIT.
REQ-004 In IDLE with div_req=1 and div_b==0, the block SHALL NOT start the core; it SHALL set HI<=div_a and LO<=32'hFFFFFFFF at that edge, with stall=0 and no state change.
REQ-005 core_start SHALL never be asserted in WAIT, even though div_req stays high.
REQ-006 stall SHALL equal (IDLE & div_req & ~flush & div_b!=0) | (WAIT & ~core_ready & ~flush).
REQ-007 In WAIT with core_ready=1 and flush=0, the block SHALL:
- set HI<=core_result[63:32] and LO<=core_result[31:0] at that edge;
- deassert stall that cycle;
- return to IDLE.
REQ-008 Divide latency is 1 launch cycle plus the core's latency; the stall window SHALL end in the core_ready cycle, so the DIV retires the following cycle.
REQ-009 Any flush in WAIT (including the core_ready cycle) SHALL return the FSM to IDLE with no HI/LO update.
REQ-010 core_ready seen in IDLE is a stale, flushed result and SHALL be ignored.
REQ-011 mthi/mtlo SHALL update HI/LO at the edge when flush=0.
REQ-012 HI/LO write priority SHALL be rst > flush (blocks all writes) > divide result (REQ-004/REQ-007) > mthi/mtlo.
REQ-013 A launch while the core is still finishing a flushed operation SHALL be allowed; the core restarts on core_start.
REQ-014 hi_out and lo_out SHALL be driven directly from the HI/LO registers, with no forwarding; EX-stage forwarding is done elsewhere.
REQ-015 Operand sign handling, magnitude conversion and the result sign fix-up SHALL remain in the core; this block passes operands through unmodified.

Reset
REQ-016 When rst=1 at an edge, the block SHALL set state=IDLE, HI=0 and LO=0; rst overrides all other inputs.
REQ-017 During rst=1, stall and core_start SHALL be forced to 0.
REQ-018 Reset during WAIT SHALL abandon the divide; a later core_ready SHALL be ignored per REQ-010.

Verification
REQ-019 DIVU with div_a=100, div_b=7 -> one core_start pulse; stall high until core_ready; then HI=2, LO=14, state=IDLE.
REQ-020 DIV with div_a=-7 (32'hFFFFFFF9), div_b=2, core returns {32'hFFFFFFFF, 32'hFFFFFFFD} -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFD; exactly one core_start while div_req is held for the whole stall.
REQ-021 div_a=5, div_b=0 -> no core_start; stall=0; next cycle HI=5, LO=32'hFFFFFFFF.
REQ-022 flush 3 cycles after launch, core_ready arrives 10 cycles later -> stall drops in the flush cycle; HI/LO keep their prior values (e.g. 32'h11111111/32'h22222222).
REQ-023 flush and core_ready in the same cycle -> no HI/LO update, state=IDLE. A new DIVU 12/5 issued in the cycle right after a flushed op's stale core_ready -> launches normally, giving HI=2, LO=2.
REQ-024 mthi=1 with mt_data=32'hDEADBEEF, then rst mid-WAIT -> HI=32'hDEADBEEF before reset; HI=LO=0, stall=0 after reset; the later core_ready is ignored.
